// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder and the MEM stage that drives it.
// Holds the FSM state encoding, default geometry and the wait-counter width.
package dmem_responder_pkg;

  localparam int DMEM_ADDR_W = 7;
  localparam int DMEM_DATA_W = 32;
  localparam int WAIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, asynchronous (combinational) read.
module dmem_array #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: storage arrays carry no reset; contents are undefined until written,
  // and leaving reset off lets the array map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the MEM-stage load/store interface: one outstanding request,
// programmable wait states, and a response held until the initiator accepts it.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  state_t                  state;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic [ADDR_W-1:0]       addr_q;
  logic                    write_q;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_dout;

  // In IDLE the array sees the live request so a store commits on the handshake edge;
  // afterwards it sees the latched address for the response read.
  assign mem_we   = (state == ST_IDLE) && req_valid && req_write;
  assign mem_addr = (state == ST_IDLE) ? req_addr : addr_q;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .din  (req_wdata),
    .dout (mem_dout)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      wait_cnt  <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            write_q   <= req_write;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (WAIT_STATES > 0) begin
              wait_cnt <= WAIT_LOAD;
              state    <= ST_WAIT;
            end else begin
              // The asynchronous read still shows the old word on this edge,
              // so a store returns its own write data directly.
              rsp_rdata <= req_write ? req_wdata : mem_dout;
              rsp_write <= req_write;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            rsp_rdata <= mem_dout;
            rsp_write <= write_q;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with three instances: WAIT_STATES = 1, 0 and 15.
module tb_dmem_responder;

  localparam int AW = 7;
  localparam int DW = 32;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [2:0]            req_valid, req_ready, req_write;
  logic [2:0][AW-1:0]    req_addr;
  logic [2:0][DW-1:0]    req_wdata, rsp_rdata;
  logic [2:0]            rsp_valid, rsp_ready, rsp_write, busy;

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_write(rsp_write[0]),
    .rsp_rdata(rsp_rdata[0]), .busy(busy[0]));

  dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_write(rsp_write[1]),
    .rsp_rdata(rsp_rdata[1]), .busy(busy[1]));

  dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(15)) dut_ws15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_write(rsp_write[2]),
    .rsp_rdata(rsp_rdata[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request on instance i and let the handshake edge pass.
  task automatic do_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    check($sformatf("ready_before_req%0d", i), 32'(req_ready[i]), 32'd1);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    tick();
    req_valid[i] = 1'b0;
  endtask

  // Cycles from handshake edge to the first edge that samples rsp_valid high.
  task automatic wait_rsp(input int i, output int cycles);
    int n = 0;
    while (!rsp_valid[i] && n < 40) begin
      tick();
      n++;
    end
    cycles = n + 1;
  endtask

  task automatic check_reset_outputs(input int i, input string tag);
    check({tag, "_req_ready"}, 32'(req_ready[i]), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid[i]), 32'd0);
    check({tag, "_rsp_write"}, 32'(rsp_write[i]), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata[i], 32'd0);
    check({tag, "_busy"},      32'(busy[i]),      32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) check_reset_outputs(i, $sformatf("reset%0d", i));
    rst_n = 1'b1;
    tick();

    // WAIT_STATES=1: store 0xDEADBEEF to addr 5, accepted immediately.
    do_req(0, 1'b1, 7'd5, 32'hDEADBEEF);
    check("st_busy_wait", 32'(busy[0]), 32'd1);
    check("st_ready_wait", 32'(req_ready[0]), 32'd0);
    wait_rsp(0, lat);
    check("st_latency", lat, 32'd2);
    check("st_rsp_write", 32'(rsp_write[0]), 32'd1);
    check("st_rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
    check("st_busy_resp", 32'(busy[0]), 32'd1);
    tick();
    check("st_rsp_drop", 32'(rsp_valid[0]), 32'd0);
    check("st_idle_busy", 32'(busy[0]), 32'd0);
    check("st_idle_ready", 32'(req_ready[0]), 32'd1);

    // Load it back.
    do_req(0, 1'b0, 7'd5, 32'h0);
    check("ld_ready_low", 32'(req_ready[0]), 32'd0);
    wait_rsp(0, lat);
    check("ld_latency", lat, 32'd2);
    check("ld_rsp_write", 32'(rsp_write[0]), 32'd0);
    check("ld_rsp_rdata", rsp_rdata[0], 32'hDEADBEEF);
    check("ld_ready_resp", 32'(req_ready[0]), 32'd0);
    tick();
    check("ld_ready_back", 32'(req_ready[0]), 32'd1);

    // WAIT_STATES=0: store 0x1 to addr 127, load queued behind it.
    do_req(1, 1'b1, 7'd127, 32'h1);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b0;
    req_wdata[1] = 32'hFFFF_FFFF;
    check("ws0_st_valid", 32'(rsp_valid[1]), 32'd1);
    check("ws0_st_write", 32'(rsp_write[1]), 32'd1);
    check("ws0_st_rdata", rsp_rdata[1], 32'h1);
    tick();
    check("ws0_idle_ready", 32'(req_ready[1]), 32'd1);
    check("ws0_idle_valid", 32'(rsp_valid[1]), 32'd0);
    tick();
    req_valid[1] = 1'b0;
    check("ws0_ld_accept", 32'(req_ready[1]), 32'd0);
    check("ws0_ld_valid", 32'(rsp_valid[1]), 32'd1);
    check("ws0_ld_write", 32'(rsp_write[1]), 32'd0);
    check("ws0_ld_rdata", rsp_rdata[1], 32'h1);
    tick();
    check("ws0_ld_done", 32'(rsp_valid[1]), 32'd0);

    // Back-pressure on the WAIT_STATES=1 instance while inputs wiggle.
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 7'd5, 32'h0);
    wait_rsp(0, lat);
    check("bp_latency", lat, 32'd2);
    for (int k = 0; k < 10; k++) begin
      req_valid[0] = k[0];
      req_write[0] = 1'b1;
      req_addr[0]  = 7'(k % 2 == 0 ? 5 : k);
      req_wdata[0] = 32'hCAFE0000 + 32'(k);
      tick();
      check($sformatf("bp_valid_%0d", k), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("bp_rdata_%0d", k), rsp_rdata[0], 32'hDEADBEEF);
      check($sformatf("bp_ready_%0d", k), 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    tick();
    check("bp_release", 32'(rsp_valid[0]), 32'd0);
    do_req(0, 1'b0, 7'd5, 32'h0);
    wait_rsp(0, lat);
    check("bp_mem_intact", rsp_rdata[0], 32'hDEADBEEF);
    tick();

    // Reset in the middle of a WAIT_STATES=15 store.
    do_req(2, 1'b1, 7'd3, 32'hA5A5A5A5);
    tick();
    tick();
    check("rst_busy_pre", 32'(busy[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(2, "rst_mid");
    tick();
    rst_n = 1'b1;
    tick();

    // WAIT_STATES=15 load of the committed word.
    do_req(2, 1'b0, 7'd3, 32'h0);
    wait_rsp(2, lat);
    check("ws15_latency", lat, 32'd16);
    check("ws15_rdata", rsp_rdata[2], 32'hA5A5A5A5);
    check("ws15_write", 32'(rsp_write[2]), 32'd0);
    tick();
    check("ws15_done", 32'(rsp_valid[2]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
